aud_sram_arb: RTL and testbench

- Owns the single-port 1M x 16 audio SRAM and shares it between the recorder (write requester) and the playback DSP (read requester).
- Sequences the global IDLE / RECORD / PLAY mode from key pulses.
- Records the end-of-recording address. The playback DSP consumes it as its final-address input.
- Sits between the key/top controller, the recorder, the playback DSP and the SRAM pins.

---
 rtl/aud_pkg.sv | 22 ++
 rtl/aud_sram_arb.sv | 177 +++++++++++++++++
 tb/tb_aud_sram_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared types and constants for the audio SRAM arbiter.
package aud_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 16;
  localparam logic [19:0] MAX_ADDR_DEF = 20'hFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC_WAIT,
    S_REC_WE,
    S_REC_HOLD,
    S_PLAY
  } state_e;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_REC  = 2'd1,
    MODE_PLAY = 2'd2
  } mode_e;

endpackage

// File: rtl/aud_sram_arb.sv
// Single-port audio SRAM arbiter: records samples from the recorder, serves reads to the
// playback DSP. The bidirectional dq pad is built at chip level from o_sram_dq / o_sram_dq_oe.
module aud_sram_arb
  import aud_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec_start,
  input  logic              i_play_start,
  input  logic              i_stop,
  input  logic              i_rec_req,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_rec_ack,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_data,
  input  logic              i_play_final,
  output logic [ADDR_W-1:0] o_final_addr,
  output logic [1:0]        o_mode,
  output logic              o_rec_full,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   final_addr_q, final_addr_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_dq_q, sram_dq_d;
  logic                rec_ack_q, rec_ack_d;
  logic                rec_full_q, rec_full_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0]   ptr_inc;

  assign ptr_inc = wr_ptr_q + ADDR_W'(1);

  // Outputs are computed for the state being entered, so every SRAM strobe is a flop.
  always_comb begin
    // NOTE: every _d gets a default here so no path leaves it unassigned (no latches).
    state_d      = state_q;
    mode_d       = mode_q;
    wr_ptr_d     = wr_ptr_q;
    final_addr_d = final_addr_q;
    sram_addr_d  = sram_addr_q;
    sram_dq_d    = sram_dq_q;
    rec_ack_d    = 1'b0;
    rec_full_d   = rec_full_q;
    we_n_d       = 1'b1;
    oe_n_d       = oe_n_q;
    dq_oe_d      = 1'b0;
    stop_pend_d  = stop_pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_rec_start) begin
          wr_ptr_d     = '0;
          final_addr_d = '0;
          rec_full_d   = 1'b0;
          stop_pend_d  = 1'b0;
          state_d      = S_REC_WAIT;
          mode_d       = MODE_REC;
        end else if (i_play_start && (final_addr_q != '0)) begin
          state_d = S_PLAY;
          mode_d  = MODE_PLAY;
          oe_n_d  = 1'b0;
        end
      end
      S_REC_WAIT: begin
        if (i_stop) begin
          final_addr_d = wr_ptr_q;
          state_d      = S_IDLE;
          mode_d       = MODE_IDLE;
        end else if (i_rec_req) begin
          sram_dq_d   = i_rec_data;
          sram_addr_d = wr_ptr_q;
          we_n_d      = 1'b0;
          dq_oe_d     = 1'b1;
          state_d     = S_REC_WE;
        end
      end
      S_REC_WE: begin
        // Data stays driven through HOLD so it outlasts the WE rising edge.
        stop_pend_d  = stop_pend_q | i_stop;
        dq_oe_d      = 1'b1;
        rec_ack_d    = 1'b1;
        wr_ptr_d     = ptr_inc;
        final_addr_d = ptr_inc;
        if (ptr_inc == MAX_ADDR) rec_full_d = 1'b1;
        state_d      = S_REC_HOLD;
      end
      S_REC_HOLD: begin
        if (rec_full_q || stop_pend_q || i_stop) begin
          stop_pend_d = 1'b0;
          state_d     = S_IDLE;
          mode_d      = MODE_IDLE;
        end else begin
          state_d = S_REC_WAIT;
        end
      end
      S_PLAY: begin
        if (i_stop || i_play_final) begin
          state_d = S_IDLE;
          mode_d  = MODE_IDLE;
          oe_n_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        mode_d  = MODE_IDLE;
        oe_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (i_rst) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_IDLE;
      wr_ptr_q     <= '0;
      final_addr_q <= '0;
      sram_addr_q  <= '0;
      sram_dq_q    <= '0;
      rec_ack_q    <= 1'b0;
      rec_full_q   <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      wr_ptr_q     <= wr_ptr_d;
      final_addr_q <= final_addr_d;
      sram_addr_q  <= sram_addr_d;
      sram_dq_q    <= sram_dq_d;
      rec_ack_q    <= rec_ack_d;
      rec_full_q   <= rec_full_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      dq_oe_q      <= dq_oe_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  // Playback reads bypass the address register so the DSP sees same-cycle data.
  assign o_sram_addr  = (state_q == S_PLAY) ? i_play_addr : sram_addr_q;
  assign o_play_data  = (state_q == S_PLAY) ? i_sram_dq : '0;
  assign o_sram_dq    = sram_dq_q;
  assign o_sram_dq_oe = dq_oe_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_rec_ack    = rec_ack_q;
  assign o_rec_full   = rec_full_q;
  assign o_final_addr = final_addr_q;
  assign o_mode       = mode_q;
  assign o_sram_ce_n  = 1'b0;
  assign o_sram_lb_n  = 1'b0;
  assign o_sram_ub_n  = 1'b0;

endmodule

// File: tb/tb_aud_sram_arb.sv
// Directed bench for aud_sram_arb with a small SRAM model; MAX_ADDR is shrunk to 4.
module tb_aud_sram_arb;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
  logic          rec_req = 1'b0;
  logic [DW-1:0] rec_data = '0;
  logic          rec_ack;
  logic [AW-1:0] play_addr = '0;
  logic [DW-1:0] play_data;
  logic          play_final = 1'b0;
  logic [AW-1:0] final_addr;
  logic [1:0]    mode;
  logic          rec_full;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [16];

  aud_sram_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(20'd4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rec_start(rec_start), .i_play_start(play_start), .i_stop(stop),
    .i_rec_req(rec_req), .i_rec_data(rec_data), .o_rec_ack(rec_ack),
    .i_play_addr(play_addr), .o_play_data(play_data), .i_play_final(play_final),
    .o_final_addr(final_addr), .o_mode(mode), .o_rec_full(rec_full),
    .o_sram_addr(sram_addr), .o_sram_dq(sram_dq_o), .o_sram_dq_oe(sram_dq_oe),
    .i_sram_dq(sram_dq_i), .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n),
    .o_sram_ce_n(sram_ce_n), .o_sram_lb_n(sram_lb_n), .o_sram_ub_n(sram_ub_n)
  );

  always #5 clk = ~clk;

  // SRAM model: latch the write in the middle of the WE-low cycle.
  always @(negedge clk) if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_o;
  assign sram_dq_i = sram_oe_n ? 16'hDEAD : mem[sram_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input logic [DW-1:0] d, input logic [AW-1:0] a);
    rec_req = 1'b1; rec_data = d;
    tick();
    check("we_low", 32'(sram_we_n), 0);
    check("wr_addr", 32'(sram_addr), 32'(a));
    check("wr_data", 32'(sram_dq_o), 32'(d));
    check("wr_dq_oe", 32'(sram_dq_oe), 1);
    check("ack_early", 32'(rec_ack), 0);
    tick();
    check("we_high_hold", 32'(sram_we_n), 1);
    check("ack", 32'(rec_ack), 1);
    check("hold_dq_oe", 32'(sram_dq_oe), 1);
    check("hold_final", 32'(final_addr), 32'(a) + 1);
    rec_req = 1'b0;
    tick();
    check("ack_drop", 32'(rec_ack), 0);
    check("dq_oe_drop", 32'(sram_dq_oe), 0);
  endtask

  initial begin
    logic [DW-1:0] samp [3];
    int writes;
    samp[0] = 16'h1234; samp[1] = 16'h8000; samp[2] = 16'h7FFF;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    rst = 1'b1; #2;
    check("rst_mode", 32'(mode), 0);
    check("rst_we_n", 32'(sram_we_n), 1);
    check("rst_oe_n", 32'(sram_oe_n), 1);
    check("rst_final", 32'(final_addr), 0);
    check("rst_full", 32'(rec_full), 0);
    check("rst_play_data", 32'(play_data), 0);
    check("rst_ce_lb_ub", {29'd0, sram_ce_n, sram_lb_n, sram_ub_n}, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Playback with nothing recorded is ignored.
    play_start = 1'b1; tick(); play_start = 1'b0;
    check("play_empty_mode", 32'(mode), 0);
    check("play_empty_oe_n", 32'(sram_oe_n), 1);

    // Record three samples, with a stray play_start in the middle.
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    check("rec_mode", 32'(mode), 1);
    write_sample(samp[0], 20'd0);
    play_start = 1'b1; tick(); play_start = 1'b0;
    check("play_in_rec_mode", 32'(mode), 1);
    check("play_in_rec_oe_n", 32'(sram_oe_n), 1);
    write_sample(samp[1], 20'd1);
    write_sample(samp[2], 20'd2);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_mode", 32'(mode), 0);
    check("stop_final", 32'(final_addr), 3);

    // Play back the three samples.
    play_start = 1'b1; tick(); play_start = 1'b0;
    check("play_mode", 32'(mode), 2);
    check("play_oe_n", 32'(sram_oe_n), 0);
    check("play_dq_oe", 32'(sram_dq_oe), 0);
    for (int a = 0; a < 3; a++) begin
      play_addr = AW'(a); #1;
      check("play_addr", 32'(sram_addr), 32'(a));
      check("play_data", 32'(play_data), 32'(samp[a]));
    end
    play_final = 1'b1; tick(); play_final = 1'b0;
    check("play_end_mode", 32'(mode), 0);
    check("play_end_oe_n", 32'(sram_oe_n), 1);
    check("play_end_final", 32'(final_addr), 3);
    check("play_end_data", 32'(play_data), 0);

    // rec_start wins over play_start; then stop arrives during the WE cycle.
    rec_start = 1'b1; play_start = 1'b1; tick(); rec_start = 1'b0; play_start = 1'b0;
    check("coincide_mode", 32'(mode), 1);
    check("coincide_final", 32'(final_addr), 0);
    rec_req = 1'b1; rec_data = 16'hA5A5; tick();
    check("stopwe_we_low", 32'(sram_we_n), 0);
    stop = 1'b1; tick(); stop = 1'b0; rec_req = 1'b0;
    check("stopwe_ack", 32'(rec_ack), 1);
    check("stopwe_mode_hold", 32'(mode), 1);
    tick();
    check("stopwe_mode", 32'(mode), 0);
    check("stopwe_final", 32'(final_addr), 1);
    check("stopwe_mem", 32'(mem[0]), 32'h0000A5A5);

    // Continuous requests fill the shrunken memory and end on their own.
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    rec_req = 1'b1;
    writes = 0;
    for (int c = 0; c < 40 && mode != 2'd0; c++) begin
      if (!sram_we_n) begin
        check("full_addr", 32'(sram_addr), 32'(writes));
        writes++;
      end
      rec_data = 16'(16'h0100 + c);
      tick();
    end
    rec_req = 1'b0;
    check("full_idle", 32'(mode), 0);
    check("full_writes", 32'(writes), 4);
    check("full_flag", 32'(rec_full), 1);
    check("full_final", 32'(final_addr), 4);

    // Reset asserted in the middle of a write cycle.
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    check("rearm_full_clr", 32'(rec_full), 0);
    rec_req = 1'b1; rec_data = 16'h5555; tick();
    check("mid_we_low", 32'(sram_we_n), 0);
    rst = 1'b1; #1;
    check("mid_rst_we_n", 32'(sram_we_n), 1);
    check("mid_rst_dq_oe", 32'(sram_dq_oe), 0);
    check("mid_rst_mode", 32'(mode), 0);
    check("mid_rst_final", 32'(final_addr), 0);
    rec_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick();
    check("post_rst_mode", 32'(mode), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
